// File: rtl/cpu64_l1_probe_unit.sv
// L1 probe responder: accepts one TileLink B probe, downgrades the L1 line via the lookup port,
// and answers on C. Define CPU64_L1_PROBE_CLEAN_DATA_EN to return data for clean T lines too.
module cpu64_l1_probe_unit #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SOURCE_W = 6,
  parameter int unsigned CID_W    = 2,
  parameter int unsigned CORE_ID  = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          tl_b_opcode_i,
  input  logic [1:0]          tl_b_param_i,
  input  logic [ADDR_W-1:0]   tl_b_address_i,
  input  logic                tl_b_valid_i,
  output logic                tl_b_ready_o,
  output logic [2:0]          tl_c_opcode_o,
  output logic [2:0]          tl_c_param_o,
  output logic [SOURCE_W-1:0] tl_c_source_o,
  output logic [ADDR_W-1:0]   tl_c_address_o,
  output logic [DATA_W-1:0]   tl_c_data_o,
  output logic                tl_c_valid_o,
  input  logic                tl_c_ready_i,
  output logic                prb_valid_o,
  output logic [ADDR_W-1:0]   prb_addr_o,
  output logic [1:0]          prb_cap_o,
  input  logic [2:0]          prb_state_i,
  output logic [2:0]          rd_word_o,
  input  logic [DATA_W-1:0]   rd_data_i
);

  localparam logic [CID_W-1:0]    CidBits = CID_W'(CORE_ID);
  localparam logic [SOURCE_W-1:0] SrcId   = {CidBits, {(SOURCE_W - CID_W){1'b0}}};

  localparam logic [2:0] OpProbeBlock   = 3'd6;
  localparam logic [2:0] OpProbeAck     = 3'd4;
  localparam logic [2:0] OpProbeAckData = 3'd5;

  typedef enum logic [2:0] {StIdle, StLookup, StRead, StSend, StAck} state_e;

  state_e              r_state, w_state_nxt;
  logic [2:0]          r_opcode;
  logic [1:0]          r_cap;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_param;
  logic [2:0]          r_beat;
  logic [DATA_W-1:0]   r_data;
  logic                r_hold;

  logic                w_perm_t, w_perm_b, w_dirty;
  logic                w_cap_t, w_cap_n;
  logic                w_need_data;
  logic [2:0]          w_param;
  logic                w_c_valid;

  assign w_perm_t = (prb_state_i[1:0] == 2'd2);
  assign w_perm_b = (prb_state_i[1:0] == 2'd1);
  assign w_dirty  = prb_state_i[2];
  assign w_cap_t  = (r_cap == 2'd0);
  // Cap encodings 2 and 3 both mean toN.
  assign w_cap_n  = r_cap[1];

  always_comb begin
    w_param = 3'd5;
    if (w_perm_t) begin
      if (w_cap_t)      w_param = 3'd3;
      else if (w_cap_n) w_param = 3'd1;
      else              w_param = 3'd0;
    end else if (w_perm_b) begin
      w_param = w_cap_n ? 3'd2 : 3'd4;
    end
  end

`ifdef CPU64_L1_PROBE_CLEAN_DATA_EN
  assign w_need_data = (r_opcode == OpProbeBlock) && w_perm_t;
`else
  assign w_need_data = (r_opcode == OpProbeBlock) && w_perm_t && w_dirty;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (tl_b_valid_i) w_state_nxt = StLookup;
      StLookup: w_state_nxt = w_need_data ? StRead : StAck;
      StRead:   w_state_nxt = StSend;
      StSend:   if (tl_c_ready_i) w_state_nxt = (r_beat == 3'd7) ? StIdle : StRead;
      StAck:    if (tl_c_ready_i) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opcode <= 3'd0;
      r_cap    <= 2'd0;
      r_addr   <= '0;
      r_param  <= 3'd0;
      r_beat   <= 3'd0;
      r_data   <= '0;
      r_hold   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (tl_b_valid_i) begin
            r_opcode <= tl_b_opcode_i;
            r_cap    <= tl_b_param_i;
            r_addr   <= {tl_b_address_i[ADDR_W-1:6], 6'b0};
          end
          r_hold <= 1'b0;
        end
        StLookup: begin
          r_param <= w_param;
          r_beat  <= 3'd0;
        end
        StRead: r_hold <= 1'b0;
        StSend: begin
          if (tl_c_ready_i) begin
            // Wraps 7 -> 0, leaving the counter at 0 for IDLE.
            r_beat <= r_beat + 3'd1;
            r_hold <= 1'b0;
          end else if (!r_hold) begin
            // Capture the beat on the first stalled cycle so the output cannot drift.
            r_data <= rd_data_i;
            r_hold <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_c_valid      = (r_state == StSend) || (r_state == StAck);
  assign tl_b_ready_o   = (r_state == StIdle);
  assign tl_c_valid_o   = w_c_valid;
  assign tl_c_opcode_o  = (r_state == StSend) ? OpProbeAckData :
                          (r_state == StAck)  ? OpProbeAck : 3'd0;
  assign tl_c_param_o   = w_c_valid ? r_param : 3'd0;
  assign tl_c_source_o  = w_c_valid ? SrcId : '0;
  assign tl_c_address_o = w_c_valid ? r_addr : '0;
  assign tl_c_data_o    = (r_state != StSend) ? '0 : (r_hold ? r_data : rd_data_i);
  assign prb_valid_o    = (r_state == StLookup);
  assign prb_addr_o     = prb_valid_o ? r_addr : '0;
  assign prb_cap_o      = prb_valid_o ? r_cap : 2'd0;
  assign rd_word_o      = r_beat;

endmodule

// File: tb/tb_cpu64_l1_probe_unit.sv
// Self-checking bench for cpu64_l1_probe_unit: directed table, hand-written corner sequences,
// and randomized probes checked against a permission-lattice reference model.
module tb_cpu64_l1_probe_unit;

`ifdef CPU64_L1_PROBE_CLEAN_DATA_EN
  localparam bit CleanData = 1'b1;
`else
  localparam bit CleanData = 1'b0;
`endif
  localparam logic [5:0] ExpSrc = 6'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  b_opcode;
  logic [1:0]  b_param;
  logic [63:0] b_addr;
  logic        b_valid;
  logic        b_ready;
  logic [2:0]  c_opcode, c_param;
  logic [5:0]  c_source;
  logic [63:0] c_address, c_data;
  logic        c_valid, c_ready;
  logic        prb_valid;
  logic [63:0] prb_addr;
  logic [1:0]  prb_cap;
  logic [2:0]  l1_state;
  logic [2:0]  rd_word;
  logic [63:0] rd_data;
  logic [63:0] mem [8];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // L1 data array with one-cycle read latency.
  always @(posedge clk) rd_data <= mem[rd_word];

  cpu64_l1_probe_unit #(
    .ADDR_W(64), .DATA_W(64), .SOURCE_W(6), .CID_W(2), .CORE_ID(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tl_b_opcode_i(b_opcode), .tl_b_param_i(b_param), .tl_b_address_i(b_addr),
    .tl_b_valid_i(b_valid), .tl_b_ready_o(b_ready),
    .tl_c_opcode_o(c_opcode), .tl_c_param_o(c_param), .tl_c_source_o(c_source),
    .tl_c_address_o(c_address), .tl_c_data_o(c_data), .tl_c_valid_o(c_valid),
    .tl_c_ready_i(c_ready),
    .prb_valid_o(prb_valid), .prb_addr_o(prb_addr), .prb_cap_o(prb_cap),
    .prb_state_i(l1_state), .rd_word_o(rd_word), .rd_data_i(rd_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Permission levels N=0, B=1, T=2; the line ends at min(current, cap).
  function automatic int perm_lvl(input logic [2:0] st);
    return (st[1:0] == 2'd2) ? 2 : (st[1:0] == 2'd1) ? 1 : 0;
  endfunction

  function automatic logic [2:0] ref_param(input logic [1:0] cap, input logic [2:0] st);
    int from, cap_lvl, to;
    int codes [3][3] = '{'{5, 0, 0}, '{2, 4, 0}, '{1, 0, 3}};
    from    = perm_lvl(st);
    cap_lvl = (cap == 2'd0) ? 2 : (cap == 2'd1) ? 1 : 0;
    to      = (from < cap_lvl) ? from : cap_lvl;
    return 3'(codes[from][to]);
  endfunction

  function automatic bit ref_need_data(input logic [2:0] op, input logic [2:0] st);
    return (op == 3'd6) && (perm_lvl(st) == 2) && (CleanData || st[2]);
  endfunction

  // Starts at a negedge with DUT idle; returns at the negedge after the final C handshake.
  task automatic do_probe(input logic [2:0] op, input logic [1:0] cap, input logic [63:0] addr,
                          input logic [2:0] st, input bit exp_data, input logic [2:0] exp_param,
                          input int stall_beat, input int stall_cyc, input bit rnd_ready,
                          input bit keep_valid, input int abort_beat);
    int cyc, beat, stalled, first, nbeats;
    logic [63:0] line;
    line   = {addr[63:6], 6'b0};
    nbeats = exp_data ? 8 : 1;
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    l1_state = st;
    b_opcode = op;
    b_param  = cap;
    b_addr   = addr;
    b_valid  = 1'b1;
    c_ready  = 1'b0;
    chk("b_ready_idle", 64'(b_ready), 64'd1);
    @(negedge clk);
    if (!keep_valid) b_valid = 1'b0;
    chk("prb_valid", 64'(prb_valid), 64'd1);
    chk("prb_addr", prb_addr, line);
    chk("prb_cap", 64'(prb_cap), 64'(cap));
    cyc = 2; beat = 0; stalled = 0; first = -1;
    while (beat < nbeats && cyc < 200) begin
      @(negedge clk);
      chk("b_ready_busy", 64'(b_ready), 64'd0);
      chk("rd_word", 64'(rd_word), exp_data ? 64'(beat) : 64'd0);
      if (c_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("latency", 64'(first), exp_data ? 64'd3 : 64'd2);
        end
        if (beat == abort_beat) begin
          rst_n = 1'b0;
          #1;
          chk("rst_c_valid", 64'(c_valid), 64'd0);
          chk("rst_rd_word", 64'(rd_word), 64'd0);
          chk("rst_b_ready", 64'(b_ready), 64'd1);
          return;
        end
        chk("c_opcode", 64'(c_opcode), exp_data ? 64'd5 : 64'd4);
        chk("c_param", 64'(c_param), 64'(exp_param));
        chk("c_source", 64'(c_source), 64'(ExpSrc));
        chk("c_address", c_address, line);
        chk("c_data", c_data, exp_data ? mem[beat] : 64'd0);
        if (beat == stall_beat && stalled < stall_cyc) begin
          c_ready = 1'b0;
          stalled++;
        end else begin
          c_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (c_ready) beat++;
      end else begin
        c_ready = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    if (beat < nbeats) chk("timeout_beats", 64'(beat), 64'(nbeats));
    @(negedge clk);
    c_ready = 1'b0;
    chk("b_ready_after", 64'(b_ready), 64'd1);
    chk("c_valid_after", 64'(c_valid), 64'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  cap;
    logic [63:0] addr;
    logic [2:0]  st;
    bit          exp_data;
    logic [2:0]  exp_param;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{3'd6, 2'd2, 64'h2047,            3'b110, 1'b1,      3'd1};
    vecs[1] = '{3'd6, 2'd1, 64'h1234_5678,       3'b001, 1'b0,      3'd4};
    vecs[2] = '{3'd7, 2'd2, 64'h80,              3'b110, 1'b0,      3'd1};
    vecs[3] = '{3'd6, 2'd2, 64'hdead_beef_0000,  3'b000, 1'b0,      3'd5};
    vecs[4] = '{3'd6, 2'd0, 64'h3fc1,            3'b010, CleanData, 3'd3};
    vecs[5] = '{3'd6, 2'd1, 64'hffff_ffff_ffff,  3'b110, 1'b1,      3'd0};
    vecs[6] = '{3'd6, 2'd2, 64'h100,             3'b101, 1'b0,      3'd2};
    vecs[7] = '{3'd7, 2'd3, 64'h7,               3'b111, 1'b0,      3'd5};
    vecs[8] = '{3'd6, 2'd0, 64'h4444,            3'b001, 1'b0,      3'd4};
    vecs[9] = '{3'd6, 2'd3, 64'h8000_0000_0000,  3'b110, 1'b1,      3'd1};

    rst_n = 1'b0; b_valid = 1'b0; b_opcode = 3'd0; b_param = 2'd0; b_addr = '0;
    c_ready = 1'b0; l1_state = 3'd0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_b_ready", 64'(b_ready), 64'd1);
    chk("reset_c_valid", 64'(c_valid), 64'd0);
    chk("reset_prb_valid", 64'(prb_valid), 64'd0);
    chk("reset_rd_word", 64'(rd_word), 64'd0);
    chk("reset_c_data", c_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_b_ready", 64'(b_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      do_probe(vecs[i].op, vecs[i].cap, vecs[i].addr, vecs[i].st, vecs[i].exp_data,
               vecs[i].exp_param, -1, 0, 1'b0, 1'b0, -1);

    // Stall three cycles on beat 3 of a dirty line.
    do_probe(3'd6, 2'd2, 64'h5a5a_5a40, 3'b110, 1'b1, 3'd1, 3, 3, 1'b0, 1'b0, -1);

    // Second probe held valid through the first response.
    do_probe(3'd6, 2'd2, 64'h9000, 3'b000, 1'b0, 3'd5, -1, 0, 1'b1, 1'b1, -1);
    do_probe(3'd6, 2'd2, 64'h9000, 3'b000, 1'b0, 3'd5, -1, 0, 1'b1, 1'b0, -1);

    // Reset during beat 5, then a fresh dirty probe.
    do_probe(3'd6, 2'd0, 64'hc0de_0000, 3'b110, 1'b1, 3'd3, -1, 0, 1'b0, 1'b0, 5);
    @(negedge clk);
    c_ready = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    do_probe(3'd6, 2'd1, 64'hc0de_0040, 3'b110, 1'b1, 3'd0, -1, 0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 25; i++) begin
      logic [2:0]  op;
      logic [1:0]  cap;
      logic [2:0]  st;
      logic [63:0] addr;
      op   = ($urandom_range(0, 1) == 1) ? 3'd6 : 3'd7;
      cap  = 2'($urandom_range(0, 3));
      st   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      do_probe(op, cap, addr, st, ref_need_data(op, st), ref_param(cap, st),
               -1, 0, 1'b1, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
